memory_response_unit: RTL and testbench

- Responder end of the memory-functional-unit request channel: accepts one load/store/IO request per cycle, performs it against an internal word-addressed data RAM or byte IO ports, and returns load/input results on the CDB as {rsv_id, data}.
- Sits between the memory functional unit's request port and the CDB arbiter. Results return strictly in request order.

---
 rtl/memory_response_unit.sv | 208 ++++++++++++++++++++
 tb/tb_memory_response_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_response_unit.sv
// Memory response unit: serves load/store/IO requests against a word RAM and byte IO ports,
// returning load/input results in order on the CDB. Define MRU_ADDR_CHECK_EN for range checks.
module memory_response_unit #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned INSTR_W      = 5,
  parameter int unsigned RSV_ID_W     = 5,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RESP_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         i_valid,
  input  logic [INSTR_W-1:0]           i_opcode,
  input  logic [RSV_ID_W-1:0]          i_rsv_id,
  input  logic [DATA_W-1:0]            i_address,
  input  logic [DATA_W-1:0]            i_data,
  output logic                         i_ready,
  output logic [RSV_ID_W+DATA_W-1:0]   o_cdb,
  output logic                         o_cdb_valid,
  input  logic                         o_cdb_ready,
  input  logic [7:0]                   io_in_data,
  input  logic                         io_in_valid,
  output logic                         io_in_ready,
  output logic [7:0]                   io_out_data,
  output logic                         io_out_valid,
  input  logic                         io_out_ready,
  output logic                         o_addr_err
);

  localparam int unsigned CDB_W = RSV_ID_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [INSTR_W-1:0] I_LOAD   = INSTR_W'(1);
  localparam logic [INSTR_W-1:0] I_LOADB  = INSTR_W'(2);
  localparam logic [INSTR_W-1:0] I_LOADR  = INSTR_W'(3);
  localparam logic [INSTR_W-1:0] I_INPUT  = INSTR_W'(4);
  localparam logic [INSTR_W-1:0] I_STORE  = INSTR_W'(5);
  localparam logic [INSTR_W-1:0] I_STOREB = INSTR_W'(6);
  localparam logic [INSTR_W-1:0] I_STORER = INSTR_W'(7);
  localparam logic [INSTR_W-1:0] I_OUTPUT = INSTR_W'(8);

  typedef enum logic {OutIdle, OutBusy} out_state_e;

  logic              w_is_load, w_is_store, w_is_input, w_is_output;
  logic              w_credit, w_acc, w_acc_rd, w_oor, w_pop, w_push;
  logic [ADDR_W-1:0] w_idx;
  logic [CDB_W-1:0]  w_push_cdb, w_s0_cdb;
  logic [DATA_W-1:0] w_s0_data;
  logic [CNT_W-1:0]  r_inflight, r_fcnt;
  out_state_e        r_out_state, w_out_state_nxt;
  logic [7:0]        r_out_data;

  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_input  = 1'b0;
    w_is_output = 1'b0;
    case (i_opcode)
      I_LOAD, I_LOADB, I_LOADR:    w_is_load   = 1'b1;
      I_STORE, I_STOREB, I_STORER: w_is_store  = 1'b1;
      I_INPUT:                     w_is_input  = 1'b1;
      I_OUTPUT:                    w_is_output = 1'b1;
      default: ;
    endcase
  end

  assign w_credit = (r_inflight < CNT_W'(RESP_DEPTH));

  // Stores and unknown opcodes are always accepted; unknown ones are simply dropped.
  always_comb begin
    i_ready = 1'b1;
    if (w_is_load)        i_ready = w_credit;
    else if (w_is_input)  i_ready = w_credit & io_in_valid;
    else if (w_is_output) i_ready = (r_out_state == OutIdle);
  end

  assign w_acc       = i_valid & i_ready & ~nrst;
  assign w_acc_rd    = w_acc & (w_is_load | w_is_input);
  assign io_in_ready = w_acc & w_is_input;
  assign w_idx       = i_address[ADDR_W-1:0];

`ifdef MRU_ADDR_CHECK_EN
  logic r_addr_err;
  assign w_oor = |i_address[DATA_W-1:ADDR_W];
  always_ff @(posedge clk) begin
    if (nrst)                                      r_addr_err <= 1'b0;
    else if (w_acc & (w_is_load | w_is_store) & w_oor) r_addr_err <= 1'b1;
  end
  assign o_addr_err = r_addr_err;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^i_address[DATA_W-1:ADDR_W];
  assign w_oor         = 1'b0;
  assign o_addr_err    = 1'b0;
`endif

  // Data RAM with a registered read port; contents survive reset.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_ram_rd;

  always_ff @(posedge clk) begin
    if (w_acc & w_is_store & ~w_oor) r_mem[w_idx] <= i_data;
    if (w_acc_rd)                    r_ram_rd     <= r_mem[w_idx];
  end

  logic                r_s0_valid, r_s0_io, r_s0_err;
  logic [RSV_ID_W-1:0] r_s0_id;
  logic [7:0]          r_s0_byte;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_s0_valid <= 1'b0;
    end else begin
      r_s0_valid <= w_acc_rd;
      if (w_acc_rd) begin
        r_s0_id   <= i_rsv_id;
        r_s0_io   <= w_is_input;
        r_s0_err  <= w_oor;
        r_s0_byte <= io_in_data;
      end
    end
  end

  always_comb begin
    if (r_s0_io)       w_s0_data = {{(DATA_W-8){1'b0}}, r_s0_byte};
    else if (r_s0_err) w_s0_data = '1;
    else               w_s0_data = r_ram_rd;
  end
  assign w_s0_cdb = {r_s0_id, w_s0_data};

  // Remaining READ_LATENCY-1 stages are a plain delay line ahead of the FIFO.
  if (READ_LATENCY > 1) begin : g_dly
    logic             r_dv [READ_LATENCY-1];
    logic [CDB_W-1:0] r_dd [READ_LATENCY-1];
    always_ff @(posedge clk) begin
      if (nrst) begin
        for (int k = 0; k < int'(READ_LATENCY) - 1; k++) r_dv[k] <= 1'b0;
      end else begin
        r_dv[0] <= r_s0_valid;
        r_dd[0] <= w_s0_cdb;
        for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
          r_dv[k] <= r_dv[k-1];
          r_dd[k] <= r_dd[k-1];
        end
      end
    end
    assign w_push     = r_dv[READ_LATENCY-2];
    assign w_push_cdb = r_dd[READ_LATENCY-2];
  end else begin : g_nodly
    assign w_push     = r_s0_valid;
    assign w_push_cdb = w_s0_cdb;
  end

  logic [CDB_W-1:0] r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_cdb_valid = (r_fcnt != '0);
  assign o_cdb       = o_cdb_valid ? r_fifo[r_rptr] : '0;
  assign w_pop       = o_cdb_valid & o_cdb_ready;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fcnt     <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_push_cdb;
        r_wptr         <= f_inc(r_wptr);
      end
      if (w_pop) r_rptr <= f_inc(r_rptr);
      r_fcnt     <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop);
      r_inflight <= r_inflight + CNT_W'(w_acc_rd) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) r_out_state <= OutIdle;
    else      r_out_state <= w_out_state_nxt;
  end

  always_comb begin
    w_out_state_nxt = r_out_state;
    unique case (r_out_state)
      OutIdle: if (w_acc & w_is_output) w_out_state_nxt = OutBusy;
      OutBusy: if (io_out_ready)        w_out_state_nxt = OutIdle;
      default:                          w_out_state_nxt = OutIdle;
    endcase
  end

  always_comb begin
    io_out_valid = (r_out_state == OutBusy);
    io_out_data  = r_out_data;
  end

  always_ff @(posedge clk) begin
    if (nrst)                         r_out_data <= 8'h00;
    else if (w_acc & w_is_output)     r_out_data <= i_data[7:0];
  end

endmodule

// File: tb/tb_memory_response_unit.sv
// Randomized scoreboard bench for memory_response_unit; expected CDB words and output bytes
// are queued at request acceptance and retired by independent monitors.
module tb_memory_response_unit;
  localparam int DATA_W = 32, ADDR_W = 10, INSTR_W = 5, RSV_ID_W = 5, RL = 2, DEPTH = 4;
  localparam logic [4:0] OP_LOAD = 5'd1, OP_LOADB = 5'd2, OP_LOADR = 5'd3, OP_INPUT = 5'd4;
  localparam logic [4:0] OP_STORE = 5'd5, OP_STOREB = 5'd6, OP_STORER = 5'd7, OP_OUTPUT = 5'd8;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        i_valid = 1'b0;
  logic [4:0]  i_opcode = '0;
  logic [4:0]  i_rsv_id = '0;
  logic [31:0] i_address = '0, i_data = '0;
  logic        i_ready;
  logic [36:0] o_cdb;
  logic        o_cdb_valid;
  logic        o_cdb_ready = 1'b0;
  logic [7:0]  io_in_data = '0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [7:0]  io_out_data;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic        o_addr_err;

  always #5 clk = ~clk;

  memory_response_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RSV_ID_W(RSV_ID_W),
    .READ_LATENCY(RL), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_opcode(i_opcode), .i_rsv_id(i_rsv_id),
    .i_address(i_address), .i_data(i_data), .i_ready(i_ready), .o_cdb(o_cdb),
    .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready), .io_in_data(io_in_data),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_out_data(io_out_data),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .o_addr_err(o_addr_err)
  );

  // Reference state
  logic [31:0] mem_model [int];
  logic [36:0] exp_q [$];
  logic [7:0]  out_q [$];
  int n_rd_acc = 0, n_pop = 0, total = 0, bad = 0, in_pulses = 0;
  bit out_pend = 0, err_model = 0;

  // Values applied to the ports at the start of the next cycle
  bit s_nrst = 1, s_cdb_rdy = 0, s_out_rdy = 0, s_in_valid = 0;
  logic [7:0] s_in_byte = '0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic bit addr_oor(input logic [31:0] a);
`ifdef MRU_ADDR_CHECK_EN
    return (a >> ADDR_W) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit v, input logic [4:0] op, input logic [4:0] id,
                      input logic [31:0] addr, input logic [31:0] data, output bit acc);
    bit ld, st, inp, outp, oor, exp_rdy;
    int idx;
    @(posedge clk);
    #1;
    nrst = s_nrst; i_valid = v; i_opcode = op; i_rsv_id = id; i_address = addr; i_data = data;
    o_cdb_ready = s_cdb_rdy; io_out_ready = s_out_rdy;
    io_in_valid = s_in_valid; io_in_data = s_in_byte;
    #1;
    ld   = op inside {OP_LOAD, OP_LOADB, OP_LOADR};
    st   = op inside {OP_STORE, OP_STOREB, OP_STORER};
    inp  = (op == OP_INPUT);
    outp = (op == OP_OUTPUT);
    exp_rdy = 1'b1;
    if (ld)        exp_rdy = (n_rd_acc - n_pop) < DEPTH;
    else if (inp)  exp_rdy = ((n_rd_acc - n_pop) < DEPTH) && s_in_valid;
    else if (outp) exp_rdy = !out_pend;
    acc = v && exp_rdy && !s_nrst;
    if (!s_nrst) begin
      if (v) check("i_ready", i_ready, exp_rdy);
      check("o_addr_err", o_addr_err, err_model);
    end
    check("io_in_ready", io_in_ready, acc && inp);
    if (io_in_ready) in_pulses++;
    if (s_nrst) begin
      exp_q.delete(); out_q.delete();
      n_rd_acc = 0; n_pop = 0; out_pend = 0; err_model = 0;
    end else if (acc) begin
      oor = (ld || st) && addr_oor(addr);
      idx = int'(addr % (1 << ADDR_W));
      if (oor) err_model = 1;
      if (st && !oor) mem_model[idx] = data;
      if (ld) begin
        n_rd_acc++;
        exp_q.push_back({id, oor ? 32'hFFFF_FFFF : mem_model[idx]});
      end
      if (inp) begin
        n_rd_acc++;
        exp_q.push_back({id, 24'h0, s_in_byte});
      end
      if (outp) begin
        out_pend = 1;
        out_q.push_back(data[7:0]);
      end
    end
  endtask

  task automatic idle();
    bit a;
    step(0, 5'd0, 5'd0, 32'd0, 32'd0, a);
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] id, input logic [31:0] addr,
                      input logic [31:0] data, input int max, input string nm);
    bit a = 0;
    for (int i = 0; i < max && !a; i++) step(1, op, id, addr, data, a);
    if (!a) begin
      total++; bad++;
      $display("FAIL %s: request not accepted within %0d cycles", nm, max);
    end
  endtask

  task automatic drain(input int max);
    s_cdb_rdy = 1; s_out_rdy = 1;
    for (int i = 0; i < max && (exp_q.size() != 0 || out_q.size() != 0); i++) idle();
    check("drain_cdb_left", exp_q.size(), 0);
    check("drain_out_left", out_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!nrst && o_cdb_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL cdb_unexpected: got %0h expected nothing", o_cdb);
      end else begin
        if (o_cdb !== exp_q[0]) begin
          bad++;
          $display("FAIL cdb_data: got %0h expected %0h", o_cdb, exp_q[0]);
        end
        if (o_cdb_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!nrst && io_out_valid) begin
      total++;
      if (out_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %0h expected nothing", io_out_data);
      end else begin
        if (io_out_data !== out_q[0]) begin
          bad++;
          $display("FAIL out_byte: got %0h expected %0h", io_out_data, out_q[0]);
        end
        if (io_out_ready) begin
          void'(out_q.pop_front());
          out_pend = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a;
    logic [4:0] op;
    logic [31:0] addr, upper;
    int r;

    idle(); idle();
    check("rst_cdb_valid", o_cdb_valid, 0);
    check("rst_cdb", o_cdb, 0);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_out_data", io_out_data, 0);
    check("rst_addr_err", o_addr_err, 0);
    s_nrst = 0;

    for (int i = 0; i < 16; i++) send(OP_STORE, 5'd0, i, $urandom, 1, "init_store");

    // Store then load next cycle; check result timing
    s_cdb_rdy = 1;
    send(OP_STORE, 5'd0, 32'd5, 32'hDEAD_BEEF, 1, "lat_store");
    send(OP_LOAD, 5'd3, 32'd5, 32'd0, 1, "lat_load");
    for (int k = 1; k <= RL + 1; k++) begin
      idle();
      check("lat_valid", o_cdb_valid, (k == RL + 1));
      if (k == RL + 1) check("lat_cdb", o_cdb, {5'd3, 32'hDEAD_BEEF});
    end
    drain(20);

    // Credit limit under CDB backpressure
    s_cdb_rdy = 0;
    for (int t = 1; t <= 4; t++) send(OP_LOAD, t, t, 32'd0, 1, "bp_load");
    for (int i = 0; i < 3; i++) begin
      step(1, OP_LOAD, 5'd5, 32'd5, 32'd0, a);
      check("bp_stall_ready", i_ready, 0);
    end
    s_cdb_rdy = 1;
    send(OP_LOAD, 5'd5, 32'd5, 32'd0, 20, "bp_load5");
    send(OP_LOAD, 5'd6, 32'd6, 32'd0, 20, "bp_load6");
    drain(30);

    // Load followed by input, order preserved
    in_pulses = 0;
    s_in_valid = 1; s_in_byte = 8'h41;
    send(OP_LOAD, 5'd2, 32'd7, 32'd0, 5, "io_load");
    send(OP_INPUT, 5'd4, 32'd0, 32'd0, 5, "io_input");
    s_in_valid = 0;
    drain(20);
    check("in_pulses", in_pulses, 1);

    // Output byte with sink stalled
    s_out_rdy = 0;
    send(OP_OUTPUT, 5'd0, 32'd0, 32'h48, 2, "out_first");
    for (int i = 0; i < 3; i++) begin
      step(1, OP_OUTPUT, 5'd0, 32'd0, 32'h49, a);
      check("out_stall_ready", i_ready, 0);
    end
    s_out_rdy = 1;
    send(OP_OUTPUT, 5'd0, 32'd0, 32'h49, 10, "out_second");
    drain(20);

    // Reset with loads in flight
    s_cdb_rdy = 0;
    for (int t = 10; t <= 12; t++) send(OP_LOAD, t, t - 10, 32'd0, 2, "rst_load");
    s_nrst = 1;
    idle();
    s_nrst = 0; s_cdb_rdy = 1;
    idle();
    check("rst_flush_valid", o_cdb_valid, 0);
    for (int i = 0; i < 8; i++) idle();
    send(OP_LOAD, 5'd9, 32'd5, 32'd0, 2, "rst_reload");
    drain(20);

`ifdef MRU_ADDR_CHECK_EN
    send(OP_LOAD, 5'd7, 32'h0000_0400, 32'd0, 2, "oor_load");
    drain(20);
    check("oor_err_set", o_addr_err, 1);
    for (int i = 0; i < 3; i++) idle();
    check("oor_err_sticky", o_addr_err, 1);
`endif

    // Randomized mix
    for (int c = 0; c < 400; c++) begin
      s_cdb_rdy  = ($urandom_range(0, 3) != 0);
      s_out_rdy  = $urandom_range(0, 1);
      s_in_valid = $urandom_range(0, 1);
      s_in_byte  = 8'($urandom);
      upper = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 32'h3F_FFFF) : 32'd0;
      addr  = (upper << ADDR_W) | $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      if (r <= 2)      op = 5'($urandom_range(1, 3));
      else if (r <= 4) op = 5'($urandom_range(5, 7));
      else if (r == 5) op = OP_INPUT;
      else if (r == 6) op = OP_OUTPUT;
      else             op = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(9, 31));
      step(r <= 7, op, 5'($urandom), addr, $urandom, a);
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
